// File: rtl/placar_pkg.sv
// Shared types and constants for the scoreboard score-update controller.
package placar_pkg;

  localparam int SCORE_W       = 7;
  localparam int MAX_SCORE_DEF = 99;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  typedef enum logic {
    TEAM_A = 1'b0,
    TEAM_B = 1'b1
  } team_t;

  localparam logic [1:0] PTS_NONE  = 2'b00;
  localparam logic [1:0] PTS_ONE   = 2'b01;
  localparam logic [1:0] PTS_TWO   = 2'b10;
  localparam logic [1:0] PTS_THREE = 2'b11;

  // The point code is numerically the point value, so widening is enough.
  function automatic logic [SCORE_W-1:0] pts_ext(input logic [1:0] p);
    return {{(SCORE_W-2){1'b0}}, p};
  endfunction

endpackage

// File: rtl/somador7bts.sv
// 7-bit ripple-carry adder built from full-adder cells; shared by both teams.
module somador7bts
  import placar_pkg::*;
(
  input  logic [SCORE_W-1:0] a,
  input  logic [SCORE_W-1:0] b,
  input  logic               cin,
  output logic [SCORE_W-1:0] s,
  output logic               cout
);

  logic [SCORE_W:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < SCORE_W; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[SCORE_W];

endmodule

// File: rtl/placar_arbitro_soma.sv
// Score-update controller: captures point requests from two teams and
// round-robins them through one shared adder, saturating at max_score.
module placar_arbitro_soma
  import placar_pkg::*;
#(
  parameter int MAX_SCORE = MAX_SCORE_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               req_a,
  input  logic [1:0]         pts_a,
  input  logic               req_b,
  input  logic [1:0]         pts_b,
  output logic [SCORE_W-1:0] score_a,
  output logic [SCORE_W-1:0] score_b,
  output logic               ack_a,
  output logic               ack_b,
  output logic               sat_a,
  output logic               sat_b,
  output logic               busy
);

  localparam logic [SCORE_W-1:0] MAX_V   = SCORE_W'(MAX_SCORE);
  localparam logic [SCORE_W:0]   MAX_SUM = (SCORE_W+1)'(MAX_SCORE);

  state_t             state;
  team_t              grant, last_grant, pick;
  logic               pend_a, pend_b;
  logic [1:0]         pts_reg_a, pts_reg_b;
  logic [SCORE_W-1:0] op_a, op_b;
  logic [SCORE_W:0]   sum_r;
  logic [SCORE_W-1:0] add_s;
  logic               add_cout;
  logic               cap_a, cap_b, commit_a, commit_b;

  somador7bts u_somador (
    .a    (op_a),
    .b    (op_b),
    .cin  (1'b0),
    .s    (add_s),
    .cout (add_cout)
  );

  assign cap_a    = req_a && (pts_a != PTS_NONE);
  assign cap_b    = req_b && (pts_b != PTS_NONE);
  assign commit_a = (state == COMMIT) && (grant == TEAM_A);
  assign commit_b = (state == COMMIT) && (grant == TEAM_B);
  // A lone pending team wins; on a tie the team that did not go last wins.
  assign pick     = (pend_a && (!pend_b || last_grant == TEAM_B)) ? TEAM_A : TEAM_B;
  assign busy     = (state != IDLE) | pend_a | pend_b;

  // NOTE: every register here uses <= so all state advances from the same
  // pre-edge values, regardless of statement order inside the block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= TEAM_A;
      last_grant <= TEAM_B;
      pend_a     <= 1'b0;
      pend_b     <= 1'b0;
      pts_reg_a  <= PTS_NONE;
      pts_reg_b  <= PTS_NONE;
      op_a       <= '0;
      op_b       <= '0;
      sum_r      <= '0;
      score_a    <= '0;
      score_b    <= '0;
      ack_a      <= 1'b0;
      ack_b      <= 1'b0;
      sat_a      <= 1'b0;
      sat_b      <= 1'b0;
    end else if (clr) begin
      state      <= IDLE;
      grant      <= TEAM_A;
      last_grant <= TEAM_B;
      pend_a     <= 1'b0;
      pend_b     <= 1'b0;
      pts_reg_a  <= PTS_NONE;
      pts_reg_b  <= PTS_NONE;
      op_a       <= '0;
      op_b       <= '0;
      sum_r      <= '0;
      score_a    <= '0;
      score_b    <= '0;
      ack_a      <= 1'b0;
      ack_b      <= 1'b0;
      sat_a      <= 1'b0;
      sat_b      <= 1'b0;
    end else begin
      ack_a <= 1'b0;
      ack_b <= 1'b0;

      // The committing team may reload its pending slot in the same cycle.
      if (commit_a) begin
        pend_a <= cap_a;
        if (cap_a) pts_reg_a <= pts_a;
      end else if (cap_a && !pend_a) begin
        pend_a    <= 1'b1;
        pts_reg_a <= pts_a;
      end

      if (commit_b) begin
        pend_b <= cap_b;
        if (cap_b) pts_reg_b <= pts_b;
      end else if (cap_b && !pend_b) begin
        pend_b    <= 1'b1;
        pts_reg_b <= pts_b;
      end

      case (state)
        IDLE: begin
          if (pend_a || pend_b) begin
            grant <= pick;
            op_a  <= (pick == TEAM_A) ? score_a : score_b;
            op_b  <= pts_ext((pick == TEAM_A) ? pts_reg_a : pts_reg_b);
            state <= CALC;
          end
        end
        CALC: begin
          sum_r <= {add_cout, add_s};
          state <= COMMIT;
        end
        COMMIT: begin
          if (grant == TEAM_A) begin
            if (sum_r > MAX_SUM) begin
              score_a <= MAX_V;
              sat_a   <= 1'b1;
            end else begin
              score_a <= sum_r[SCORE_W-1:0];
            end
            ack_a <= 1'b1;
          end else begin
            if (sum_r > MAX_SUM) begin
              score_b <= MAX_V;
              sat_b   <= 1'b1;
            end else begin
              score_b <= sum_r[SCORE_W-1:0];
            end
            ack_b <= 1'b1;
          end
          last_grant <= grant;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_placar_arbitro_soma.sv
// Directed bench for placar_arbitro_soma: per-cycle vector table plus
// hand-written multi-cycle sequences (drop/reload, clr, saturation, async reset).
module tb_placar_arbitro_soma;

  logic       clk = 1'b0;
  logic       rst, clr;
  logic       req_a, req_b;
  logic [1:0] pts_a, pts_b;
  logic [6:0] score_a, score_b;
  logic       ack_a, ack_b, sat_a, sat_b, busy;

  int n_cmp  = 0;
  int n_fail = 0;

  placar_arbitro_soma #(.MAX_SCORE(99)) dut (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr),
    .req_a   (req_a),
    .pts_a   (pts_a),
    .req_b   (req_b),
    .pts_b   (pts_b),
    .score_a (score_a),
    .score_b (score_b),
    .ack_a   (ack_a),
    .ack_b   (ack_b),
    .sat_a   (sat_a),
    .sat_b   (sat_b),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       req_a;
    logic [1:0] pts_a;
    logic       req_b;
    logic [1:0] pts_b;
    logic [6:0] sa;
    logic [6:0] sb;
    logic       ka;
    logic       kb;
    logic       bsy;
  } vec_t;

  vec_t vecs[$];

  function automatic void v(input logic ra, input logic [1:0] pa,
                            input logic rb, input logic [1:0] pb,
                            input int sa, input int sb,
                            input logic ka, input logic kb, input logic bsy);
    vec_t r;
    r.req_a = ra; r.pts_a = pa; r.req_b = rb; r.pts_b = pb;
    r.sa = 7'(sa); r.sb = 7'(sb); r.ka = ka; r.kb = kb; r.bsy = bsy;
    vecs.push_back(r);
  endfunction

  // {score_a, score_b, ack_a, ack_b, sat_a, sat_b, busy}
  function automatic logic [18:0] outs();
    return {score_a, score_b, ack_a, ack_b, sat_a, sat_b, busy};
  endfunction

  function automatic logic [18:0] pack(input int sa, input int sb, input logic ka,
                                       input logic kb, input logic ta, input logic tb,
                                       input logic bsy);
    return {7'(sa), 7'(sb), ka, kb, ta, tb, bsy};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_a = 1'b0; pts_a = 2'b00; req_b = 1'b0; pts_b = 2'b00;
  endtask

  // One full team-A update: request at edge N, committed at N+3.
  task automatic add_a(input logic [1:0] p);
    req_a = 1'b1; pts_a = p;
    tick();
    idle_inputs();
    tick(); tick(); tick();
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0;
    idle_inputs();
    tick(); tick();
    rst = 1'b0;
    check("reset_state", 32'(outs()), 32'(pack(0, 0, 0, 0, 0, 0, 0)));

    // Tie (A first), single A, tie after A (B first), pts=00 ignored.
    v(1, 2'b01, 1, 2'b10, 0, 0, 0, 0, 1);
    v(0, 2'b00, 0, 2'b00, 0, 0, 0, 0, 1);
    v(0, 2'b00, 0, 2'b00, 0, 0, 0, 0, 1);
    v(0, 2'b00, 0, 2'b00, 1, 0, 1, 0, 1);
    v(0, 2'b00, 0, 2'b00, 1, 0, 0, 0, 1);
    v(0, 2'b00, 0, 2'b00, 1, 0, 0, 0, 1);
    v(0, 2'b00, 0, 2'b00, 1, 2, 0, 1, 0);
    v(0, 2'b00, 0, 2'b00, 1, 2, 0, 0, 0);
    v(1, 2'b11, 0, 2'b00, 1, 2, 0, 0, 1);
    v(0, 2'b00, 0, 2'b00, 1, 2, 0, 0, 1);
    v(0, 2'b00, 0, 2'b00, 1, 2, 0, 0, 1);
    v(0, 2'b00, 0, 2'b00, 4, 2, 1, 0, 0);
    v(0, 2'b00, 0, 2'b00, 4, 2, 0, 0, 0);
    v(1, 2'b01, 1, 2'b01, 4, 2, 0, 0, 1);
    v(0, 2'b00, 0, 2'b00, 4, 2, 0, 0, 1);
    v(0, 2'b00, 0, 2'b00, 4, 2, 0, 0, 1);
    v(0, 2'b00, 0, 2'b00, 4, 3, 0, 1, 1);
    v(0, 2'b00, 0, 2'b00, 4, 3, 0, 0, 1);
    v(0, 2'b00, 0, 2'b00, 4, 3, 0, 0, 1);
    v(0, 2'b00, 0, 2'b00, 5, 3, 1, 0, 0);
    v(0, 2'b00, 0, 2'b00, 5, 3, 0, 0, 0);
    v(1, 2'b00, 1, 2'b00, 5, 3, 0, 0, 0);
    v(0, 2'b00, 0, 2'b00, 5, 3, 0, 0, 0);

    foreach (vecs[i]) begin
      req_a = vecs[i].req_a; pts_a = vecs[i].pts_a;
      req_b = vecs[i].req_b; pts_b = vecs[i].pts_b;
      tick();
      check($sformatf("vec%0d", i), 32'(outs()),
            32'(pack(vecs[i].sa, vecs[i].sb, vecs[i].ka, vecs[i].kb, 0, 0, vecs[i].bsy)));
    end
    idle_inputs();

    // Request during CALC is dropped; request in the commit cycle reloads.
    req_a = 1'b1; pts_a = 2'b01;
    tick();
    idle_inputs();
    tick();
    req_a = 1'b1; pts_a = 2'b11;
    tick();
    req_a = 1'b1; pts_a = 2'b10;
    tick();
    idle_inputs();
    check("reload_commit", 32'(outs()), 32'(pack(6, 3, 1, 0, 0, 0, 1)));
    tick(); tick(); tick();
    check("reload_applied", 32'(outs()), 32'(pack(8, 3, 1, 0, 0, 0, 0)));
    tick();
    check("reload_no_extra", 32'(outs()), 32'(pack(8, 3, 0, 0, 0, 0, 0)));

    // clr while B is in CALC aborts the update without an ack.
    req_b = 1'b1; pts_b = 2'b01;
    tick();
    idle_inputs();
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr_in_calc", 32'(outs()), 32'(pack(0, 0, 0, 0, 0, 0, 0)));
    tick(); tick();
    check("clr_no_ack", 32'(outs()), 32'(pack(0, 0, 0, 0, 0, 0, 0)));

    // Exactly MAX_SCORE is not a clamp; one more point is.
    for (int i = 0; i < 33; i++) add_a(2'b11);
    check("exact_max", 32'(outs()), 32'(pack(99, 0, 1, 0, 0, 0, 0)));
    add_a(2'b01);
    check("clamp_from_max", 32'(outs()), 32'(pack(99, 0, 1, 0, 1, 0, 0)));
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr_sat", 32'(outs()), 32'(pack(0, 0, 0, 0, 0, 0, 0)));

    for (int i = 0; i < 32; i++) add_a(2'b11);
    add_a(2'b10);
    check("score_98", 32'(outs()), 32'(pack(98, 0, 1, 0, 0, 0, 0)));
    add_a(2'b10);
    check("sat_98_plus_2", 32'(outs()), 32'(pack(99, 0, 1, 0, 1, 0, 0)));
    add_a(2'b11);
    check("sat_sticky", 32'(outs()), 32'(pack(99, 0, 1, 0, 1, 0, 0)));

    // Async reset mid-transaction clears outputs before any clock edge.
    req_b = 1'b1; pts_b = 2'b11;
    tick();
    idle_inputs();
    tick();
    #2 rst = 1'b1;
    #1;
    check("async_rst", 32'(outs()), 32'(pack(0, 0, 0, 0, 0, 0, 0)));
    tick();
    rst = 1'b0;
    req_a = 1'b1; pts_a = 2'b01; req_b = 1'b1; pts_b = 2'b01;
    tick();
    idle_inputs();
    tick(); tick(); tick();
    check("tie_after_rst", 32'(outs()), 32'(pack(1, 0, 1, 0, 0, 0, 1)));
    tick(); tick(); tick();
    check("tie_after_rst_b", 32'(outs()), 32'(pack(1, 1, 0, 1, 0, 0, 0)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
